// File: rtl/lsu_pkg.sv
// Shared types for the word-only load/store bridge.
// Access sizes, FSM states and the datapath width.
package lsu_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        SZ_B   = 2'd0,
        SZ_H   = 2'd1,
        SZ_W   = 2'd2,
        SZ_BAD = 2'd3
    } lsu_size_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WRITE  = 2'd2,
        RESP   = 2'd3
    } lsu_state_t;

endpackage

// File: rtl/lsu_word_bridge_lane_align.sv
// Lane extract/extend for loads and lane merge for sub-word stores.
// Purely combinational; lane selects come from the low address bits.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [XLEN-1:0] rdata_i,
    input  logic [XLEN-1:0] wdata_i,
    input  logic [1:0]      lane_i,
    input  lsu_size_t       size_i,
    input  logic            uns_i,
    output logic [XLEN-1:0] load_o,
    output logic [XLEN-1:0] merge_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Pick the addressed lane, extend it, and build the merged write word
    always_comb begin
        byte_sel = rdata_i[{lane_i, 3'b000} +: 8];
        half_sel = rdata_i[{lane_i[1], 4'b0000} +: 16];
        load_o   = rdata_i;
        merge_o  = wdata_i;
        case (size_i)
            SZ_B: begin
                load_o  = uns_i ? {24'b0, byte_sel}
                                : {{24{byte_sel[7]}}, byte_sel};
                merge_o = rdata_i;
                merge_o[{lane_i, 3'b000} +: 8] = wdata_i[7:0];
            end
            SZ_H: begin
                load_o  = uns_i ? {16'b0, half_sel}
                                : {{16{half_sel[15]}}, half_sel};
                merge_o = rdata_i;
                merge_o[{lane_i[1], 4'b0000} +: 16] = wdata_i[15:0];
            end
            default: begin
                load_o  = rdata_i;
                merge_o = wdata_i;
            end
        endcase
    end

endmodule

// File: rtl/lsu_word_bridge.sv
// Byte/half/word load-store front end for a word-only memory port.
// Sub-word stores are done as read-modify-write; mem_we is a flop.
module lsu_word_bridge
    import lsu_pkg::*;
#(
    parameter int ADDR_BITS = 12,
    parameter int XLEN      = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [1:0]      req_size,
    input  logic            req_unsigned,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            rsp_valid,
    output logic [XLEN-1:0] rsp_rdata,
    output logic            rsp_misaligned,
    output logic            rsp_fault,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic            mem_we,
    input  logic [XLEN-1:0] mem_rdata
);

    if (XLEN != 32) begin : g_xlen_chk
        $error("lsu_word_bridge supports XLEN = 32 only");
    end

    lsu_state_t        state_q, state_d;
    lsu_size_t         size_q, size_d;
    logic [1:0]        lane_q, lane_d;
    logic              we_q, we_d;
    logic              uns_q, uns_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic [XLEN-1:0]   maddr_q, maddr_d;
    logic [XLEN-1:0]   mwdata_q, mwdata_d;
    logic              mwe_q, mwe_d;
    logic [XLEN-1:0]   rdata_q, rdata_d;
    logic              mis_q, mis_d;
    logic              flt_q, flt_d;

    logic              accept;
    logic              req_mis;
    logic              req_flt;
    lsu_size_t         req_sz;
    logic [XLEN-1:0]   load_val;
    logic [XLEN-1:0]   merge_val;

    assign req_ready      = (state_q == IDLE);
    assign rsp_valid      = (state_q == RESP);
    assign rsp_rdata      = rdata_q;
    assign rsp_misaligned = mis_q;
    assign rsp_fault      = flt_q;
    assign mem_addr       = maddr_q;
    assign mem_wdata      = mwdata_q;
    assign mem_we         = mwe_q;

    assign accept  = req_valid && req_ready;
    assign req_sz  = lsu_size_t'(req_size);
    assign req_flt = |req_addr[XLEN-1:ADDR_BITS];

    // Alignment / illegal-size check on the incoming request
    always_comb begin
        req_mis = 1'b0;
        unique case (1'b1)
            (req_sz == SZ_BAD): req_mis = 1'b1;
            (req_sz == SZ_H):   req_mis = req_addr[0];
            (req_sz == SZ_W):   req_mis = |req_addr[1:0];
            default:            req_mis = 1'b0;
        endcase
    end

    lsu_lane_align u_align (
        .rdata_i (mem_rdata),
        .wdata_i (wdata_q),
        .lane_i  (lane_q),
        .size_i  (size_q),
        .uns_i   (uns_q),
        .load_o  (load_val),
        .merge_o (merge_val)
    );

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            size_q   <= SZ_B;
            lane_q   <= 2'b0;
            we_q     <= 1'b0;
            uns_q    <= 1'b0;
            wdata_q  <= '0;
            maddr_q  <= '0;
            mwdata_q <= '0;
            mwe_q    <= 1'b0;
            rdata_q  <= '0;
            mis_q    <= 1'b0;
            flt_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            size_q   <= size_d;
            lane_q   <= lane_d;
            we_q     <= we_d;
            uns_q    <= uns_d;
            wdata_q  <= wdata_d;
            maddr_q  <= maddr_d;
            mwdata_q <= mwdata_d;
            mwe_q    <= mwe_d;
            rdata_q  <= rdata_d;
            mis_q    <= mis_d;
            flt_q    <= flt_d;
        end
    end

    // Next-state and register updates for the access sequence
    always_comb begin
        state_d  = state_q;
        size_d   = size_q;
        lane_d   = lane_q;
        we_d     = we_q;
        uns_d    = uns_q;
        wdata_d  = wdata_q;
        maddr_d  = maddr_q;
        mwdata_d = mwdata_q;
        mwe_d    = mwe_q;
        rdata_d  = rdata_q;
        mis_d    = mis_q;
        flt_d    = flt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    size_d  = req_sz;
                    lane_d  = req_addr[1:0];
                    we_d    = req_we;
                    uns_d   = req_unsigned;
                    wdata_d = req_wdata;
                    if (req_mis || req_flt) begin
                        mis_d   = req_mis;
                        flt_d   = !req_mis && req_flt;
                        rdata_d = '0;
                        state_d = RESP;
                    end else begin
                        maddr_d = {req_addr[XLEN-1:2], 2'b00};
                        if (req_we && req_sz == SZ_W) begin
                            mwdata_d = req_wdata;
                            mwe_d    = 1'b1;
                        end
                        state_d = ACCESS;
                    end
                end
            end
            ACCESS: begin
                mis_d   = 1'b0;
                flt_d   = 1'b0;
                rdata_d = '0;
                if (!we_q) begin
                    rdata_d = load_val;
                    state_d = RESP;
                end else if (size_q == SZ_W) begin
                    mwe_d   = 1'b0;
                    state_d = RESP;
                end else begin
                    mwdata_d = merge_val;
                    mwe_d    = 1'b1;
                    state_d  = WRITE;
                end
            end
            WRITE: begin
                mwe_d   = 1'b0;
                state_d = RESP;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_lsu_word_bridge.sv
// Directed self-checking bench for lsu_word_bridge.
// Word memory model with combinational read and clocked write.
module tb_lsu_word_bridge;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_misaligned;
    logic        rsp_fault;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [31:0] mem_rdata;

    logic [31:0] mem [0:1023];

    int checks;
    int errors;

    lsu_word_bridge #(.ADDR_BITS(12), .XLEN(32)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_we         (req_we),
        .req_size       (req_size),
        .req_unsigned   (req_unsigned),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .rsp_valid      (rsp_valid),
        .rsp_rdata      (rsp_rdata),
        .rsp_misaligned (rsp_misaligned),
        .rsp_fault      (rsp_fault),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_we         (mem_we),
        .mem_rdata      (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[11:2]];

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr[11:2]] <= mem_wdata;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_req(input string tag, input logic we,
                          input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input int exp_lat, input int exp_we,
                          input logic [31:0] exp_maddr,
                          input logic [31:0] exp_mwdata,
                          input logic [31:0] exp_rdata,
                          input logic exp_mis, input logic exp_flt);
        int lat;
        int wec;
        lat = 0;
        wec = 0;
        @(negedge clk);
        chk({tag, ".ready"}, {31'b0, req_ready}, 32'd1);
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wd;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            lat++;
            if (mem_we) begin
                wec++;
                chk({tag, ".maddr"}, mem_addr, exp_maddr);
                chk({tag, ".mwdata"}, mem_wdata, exp_mwdata);
            end
            if (rsp_valid) break;
        end
        chk({tag, ".lat"}, lat, exp_lat);
        chk({tag, ".wecnt"}, wec, exp_we);
        chk({tag, ".rdata"}, rsp_rdata, exp_rdata);
        chk({tag, ".mis"}, {31'b0, rsp_misaligned}, {31'b0, exp_mis});
        chk({tag, ".flt"}, {31'b0, rsp_fault}, {31'b0, exp_flt});
    endtask

    logic [31:0] b2b_exp [0:2];
    int          rc;
    int          idx;
    int          lowcnt;
    int          rvcnt;

    initial begin
        checks       = 0;
        errors       = 0;
        rst_n        = 1'b0;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_size     = 2'd0;
        req_unsigned = 1'b0;
        req_addr     = '0;
        req_wdata    = '0;
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        mem[32'h40] = 32'h8899AABB;

        repeat (2) @(negedge clk);
        chk("rst.ready", {31'b0, req_ready}, 32'd1);
        chk("rst.rspv", {31'b0, rsp_valid}, 32'd0);
        chk("rst.we", {31'b0, mem_we}, 32'd0);
        chk("rst.maddr", mem_addr, 32'h0);
        chk("rst.mwdata", mem_wdata, 32'h0);
        chk("rst.rdata", rsp_rdata, 32'h0);
        rst_n = 1'b1;

        do_req("lb103", 0, 2'd0, 0, 32'h103, 0, 2, 0, 0, 0,
               32'hFFFFFF88, 0, 0);
        do_req("lhu102", 0, 2'd1, 1, 32'h102, 0, 2, 0, 0, 0,
               32'h00008899, 0, 0);
        do_req("lh100", 0, 2'd1, 0, 32'h100, 0, 2, 0, 0, 0,
               32'hFFFFAABB, 0, 0);
        do_req("lbu100", 0, 2'd0, 1, 32'h100, 0, 2, 0, 0, 0,
               32'h000000BB, 0, 0);
        do_req("sb101", 1, 2'd0, 0, 32'h101, 32'h0000005A, 3, 1,
               32'h100, 32'h88995ABB, 32'h0, 0, 0);
        do_req("lw100a", 0, 2'd2, 0, 32'h100, 0, 2, 0, 0, 0,
               32'h88995ABB, 0, 0);
        do_req("lw102", 0, 2'd2, 0, 32'h102, 0, 1, 0, 0, 0,
               32'h0, 1, 0);
        do_req("sw1000", 1, 2'd2, 0, 32'h1000, 32'h11223344, 1, 0,
               0, 0, 32'h0, 0, 1);
        do_req("lw1001", 0, 2'd2, 0, 32'h1001, 0, 1, 0, 0, 0,
               32'h0, 1, 0);
        do_req("lh101", 0, 2'd1, 0, 32'h101, 0, 1, 0, 0, 0,
               32'h0, 1, 0);
        do_req("sz3", 0, 2'd3, 0, 32'h100, 0, 1, 0, 0, 0,
               32'h0, 1, 0);
        do_req("sh102", 1, 2'd1, 0, 32'h102, 32'hFFFF1234, 3, 1,
               32'h100, 32'h12345ABB, 32'h0, 0, 0);
        do_req("sw104", 1, 2'd2, 0, 32'h104, 32'hDEADBEEF, 2, 1,
               32'h104, 32'hDEADBEEF, 32'h0, 0, 0);
        do_req("lw104", 0, 2'd2, 0, 32'h104, 0, 2, 0, 0, 0,
               32'hDEADBEEF, 0, 0);

        b2b_exp[0] = 32'h12345ABB;
        b2b_exp[1] = 32'h0;
        b2b_exp[2] = 32'hDEADBE77;
        rc     = 0;
        idx    = 0;
        lowcnt = 0;
        for (int c = 0; c < 40 && rc < 3; c++) begin
            @(negedge clk);
            if (rsp_valid) begin
                chk($sformatf("b2b.rdata%0d", rc), rsp_rdata, b2b_exp[rc]);
                rc++;
            end
            if (req_ready) begin
                if (idx < 3) begin
                    req_valid    = 1'b1;
                    req_unsigned = 1'b0;
                    req_wdata    = 32'h00000077;
                    case (idx)
                        0: begin
                            req_we = 0; req_size = 2'd2; req_addr = 32'h100;
                        end
                        1: begin
                            req_we = 1; req_size = 2'd0; req_addr = 32'h104;
                        end
                        default: begin
                            req_we = 0; req_size = 2'd2; req_addr = 32'h104;
                        end
                    endcase
                    idx++;
                end else begin
                    req_valid = 1'b0;
                end
            end else begin
                lowcnt++;
            end
        end
        req_valid = 1'b0;
        chk("b2b.rspcnt", rc, 3);
        chk("b2b.lowcnt", lowcnt, 7);

        @(negedge clk);
        req_valid    = 1'b1;
        req_we       = 1'b1;
        req_size     = 2'd1;
        req_unsigned = 1'b0;
        req_addr     = 32'h106;
        req_wdata    = 32'h0000CAFE;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rstw.we_hi", {31'b0, mem_we}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("rstw.we_lo", {31'b0, mem_we}, 32'd0);
        chk("rstw.rspv", {31'b0, rsp_valid}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        rvcnt = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (rsp_valid) rvcnt++;
        end
        chk("rstw.norsp", rvcnt, 0);
        chk("rstw.ready", {31'b0, req_ready}, 32'd1);
        checks++;
        assert (mem[32'h41] === 32'hDEADBE77 ||
                mem[32'h41] === 32'hCAFEBE77) else begin
            errors++;
            $error("FAIL rstw.mem observed=%h expected=DEADBE77|CAFEBE77",
                   mem[32'h41]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
